// File: rtl/apb_pkg.sv
// Shared types and constants for the generic-bus to APB4 bridge.
package apb_pkg;

    // Widest address/data the request register is sized for; a bridge
    // instance uses the low bits only.
    localparam int ADDR_MAX = 64;
    localparam int DATA_MAX = 64;
    localparam int STRB_MAX = DATA_MAX / 8;

    // Slave index width, enough for the 16-slave maximum.
    localparam int IDX_W = 4;

    // PPROT bit meanings (APB4).
    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        ACCESS   = 2'd2,
        RESP_ERR = 2'd3
    } apb_state_t;

    // Request captured in IDLE and replayed on the APB side.
    typedef struct packed {
        logic [ADDR_MAX-1:0] addr;
        logic [DATA_MAX-1:0] wdata;
        logic [STRB_MAX-1:0] strb;
        logic                write;
        logic [IDX_W-1:0]    idx;
    } apb_req_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode into the APB slave window: one region of
// 2^REGION_LOG2 bytes per slave, starting at BASE_ADDR.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                NSLV        = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int                REGION_LOG2 = 12
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic [IDX_W-1:0]  idx,
    output logic [NSLV-1:0]   onehot
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] slot;
    logic              in_range;

    // Offset from the window base, region number, and range check; the
    // full-width region number is compared so large offsets never alias.
    always_comb begin
        offset   = addr - BASE_ADDR;
        in_range = (addr >= BASE_ADDR);
        slot     = offset >> REGION_LOG2;
        valid    = in_range && (slot < ADDR_W'(NSLV));
        idx      = slot[IDX_W-1:0];
        onehot   = '0;
        for (int i = 0; i < NSLV; i++) begin
            onehot[i] = valid && (slot == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/apb_multi_bridge.sv
// Generic bus to APB4 bridge with N-slave decode, SETUP/ACCESS sequencing,
// PSLVERR propagation, decode-error response and optional PREADY timeout.
//
// Requester handshake: ren/wen are sampled only while the bridge is idle
// (busy=1 and no transfer in flight); once accepted, requester inputs are
// ignored until completion. Completion is the single cycle with busy=0,
// where error and rdata are valid. busy is high in every other cycle.
module apb_multi_bridge
    import apb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NSLV        = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
    parameter int                REGION_LOG2 = 12,
    parameter int                TIMEOUT     = 0,
    parameter logic [2:0]        PPROT_VAL   = 3'b000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   ren,
    input  logic                   wen,
    input  logic [DATA_W/8-1:0]    byte_en,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic                   error,
    output logic [ADDR_W-1:0]      PADDR,
    output logic [NSLV-1:0]        PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_W-1:0]      PWDATA,
    output logic [DATA_W/8-1:0]    PSTRB,
    output logic [2:0]             PPROT,
    input  logic [NSLV*DATA_W-1:0] PRDATA,
    input  logic [NSLV-1:0]        PREADY,
    input  logic [NSLV-1:0]        PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // FSM state is kept as a named signal so checkers can bind to it.
    apb_state_t       state;
    apb_state_t       state_next;
    apb_req_t         req;
    logic [NSLV-1:0]  sel_q;
    logic [CNT_W-1:0] cnt;

    logic             start;
    logic             dec_valid;
    logic [IDX_W-1:0] dec_idx;
    logic [NSLV-1:0]  dec_onehot;

    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              timed_out;

    // Padding bits of the request register are intentionally not read.
    logic unused_req;
    assign unused_req = ^req;

    assign start = ren | wen;
    assign PPROT = PPROT_VAL;

    apb_addr_decoder #(
        .ADDR_W      (ADDR_W),
        .NSLV        (NSLV),
        .BASE_ADDR   (BASE_ADDR),
        .REGION_LOG2 (REGION_LOG2)
    ) u_dec (
        .addr   (addr),
        .valid  (dec_valid),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    // Pick the selected slave's response; other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (req.idx == IDX_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request and decoded select when a transfer is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req   <= '0;
            sel_q <= '0;
        end else if (state == IDLE && start) begin
            req.addr  <= ADDR_MAX'(addr);
            req.wdata <= DATA_MAX'(wdata);
            req.strb  <= wen ? STRB_MAX'(byte_en) : '0;
            req.write <= wen;
            req.idx   <= dec_idx;
            sel_q     <= dec_onehot;
        end
    end

    // Wait-state counter: counts ACCESS cycles without PREADY, saturating.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (state == ACCESS && !sel_ready) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Next-state logic and all bus/requester outputs.
    always_comb begin
        state_next = state;
        PSEL       = '0;
        PENABLE    = 1'b0;
        PADDR      = '0;
        PWRITE     = 1'b0;
        PWDATA     = '0;
        PSTRB      = '0;
        busy       = 1'b1;
        error      = 1'b0;
        rdata      = '0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = dec_valid ? SETUP : RESP_ERR;
                end
            end
            SETUP: begin
                PSEL       = sel_q;
                PADDR      = req.addr[ADDR_W-1:0];
                PWRITE     = req.write;
                PWDATA     = req.wdata[DATA_W-1:0];
                PSTRB      = req.strb[STRB_W-1:0];
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = sel_q;
                PENABLE = 1'b1;
                PADDR   = req.addr[ADDR_W-1:0];
                PWRITE  = req.write;
                PWDATA  = req.wdata[DATA_W-1:0];
                PSTRB   = req.strb[STRB_W-1:0];
                if (sel_ready) begin
                    busy       = 1'b0;
                    error      = sel_err;
                    rdata      = req.write ? '0 : sel_rdata;
                    state_next = IDLE;
                end else if (timed_out) begin
                    state_next = RESP_ERR;
                end
            end
            RESP_ERR: begin
                busy       = 1'b0;
                error      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_multi_bridge.sv
// Self-checking bench for apb_multi_bridge (NSLV=4, TIMEOUT=4).
// Every cycle's expected outputs are derived from the transaction being
// driven and the decode/latency rules, queued, and compared at negedge.
module tb_apb_multi_bridge;

    localparam int          NSLV    = 4;
    localparam int          TIMEOUT = 4;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam longint      REGION  = 4096;
    localparam int          EW      = 111;

    // Clock/reset and DUT connections.
    logic          CLK;
    logic          RST;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          ren;
    logic          wen;
    logic [3:0]    byte_en;
    logic [31:0]   rdata;
    logic          busy;
    logic          error;
    logic [31:0]   PADDR;
    logic [3:0]    PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [127:0]  PRDATA;
    logic [3:0]    PREADY;
    logic [3:0]    PSLVERR;

    apb_multi_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NSLV        (NSLV),
        .BASE_ADDR   (BASE),
        .REGION_LOG2 (12),
        .TIMEOUT     (TIMEOUT),
        .PPROT_VAL   (3'b000)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .addr    (addr),
        .wdata   (wdata),
        .ren     (ren),
        .wen     (wen),
        .byte_en (byte_en),
        .rdata   (rdata),
        .busy    (busy),
        .error   (error),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PPROT   (PPROT),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard state.
    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    logic [EW-1:0] act;
    int            n_checks = 0;
    int            n_pass   = 0;

    // Per-transaction observations used by the literal checks.
    int          cyc_k;
    int          res_lat;
    logic [3:0]  res_psel;
    logic [31:0] res_rdata;
    logic        res_err;

    assign act = {PSEL, PENABLE, PWRITE, PSTRB, busy, error, PPROT, PADDR, PWDATA, rdata};

    function automatic logic [EW-1:0] mk(input logic [3:0] psel, input logic pen,
                                         input logic pwr, input logic [3:0] strb,
                                         input logic bsy, input logic err,
                                         input logic [31:0] pa, input logic [31:0] pwd,
                                         input logic [31:0] rd);
        return {psel, pen, pwr, strb, bsy, err, 3'b000, pa, pwd, rd};
    endfunction

    // Reference decode: region number from plain arithmetic.
    function automatic void decode(input logic [31:0] a, output bit ok, output int idx);
        longint off;
        ok  = 1'b0;
        idx = 0;
        if (a >= BASE) begin
            off = longint'(a) - longint'(BASE);
            idx = int'(off / REGION);
            ok  = (idx < NSLV);
        end
    endfunction

    // Compare process: one queued expectation per cycle.
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        string         nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, e);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic rand_slaves();
        PREADY  = 4'($urandom);
        PSLVERR = 4'($urandom);
        PRDATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic rand_req();
        addr    = $urandom();
        wdata   = $urandom();
        byte_en = 4'($urandom);
        ren     = 1'($urandom);
        wen     = 1'($urandom);
    endtask

    // One clock cycle: queue its expectation, observe at negedge, advance.
    task automatic cyc(input logic [EW-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        cyc_k++;
        @(negedge CLK);
        if (cyc_k == 2) res_psel = PSEL;
        if (busy === 1'b0 && res_lat == 0) begin
            res_lat   = cyc_k;
            res_rdata = rdata;
            res_err   = error;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rand_req();
            ren = 1'b0;
            wen = 1'b0;
            rand_slaves();
            cyc(mk(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0), "idle");
        end
    endtask

    // Drive one transfer; waits = PREADY-low ACCESS cycles, rst_at = ACCESS
    // cycle index in which RST is pulsed (-1 for none).
    task automatic run_txn(input bit is_wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int waits, input bit slverr,
                           input logic [31:0] rd, input int rst_at);
        bit            ok;
        int            idx;
        bit            rdy;
        logic [3:0]    oh;
        logic [3:0]    strb;
        logic [31:0]   exp_rd;
        logic [EW-1:0] idle_e;
        logic [EW-1:0] err_e;
        cyc_k     = 0;
        res_lat   = 0;
        res_psel  = 4'b0;
        res_rdata = 32'h0;
        res_err   = 1'b0;
        decode(a, ok, idx);
        oh     = ok ? 4'(1 << idx) : 4'b0;
        strb   = is_wr ? be : 4'b0;
        idle_e = mk(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        err_e  = mk(4'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

        rand_slaves();
        addr    = a;
        wdata   = wd;
        byte_en = be;
        wen     = is_wr;
        ren     = is_wr ? 1'($urandom) : 1'b1;
        cyc(idle_e, "idle_req");

        rand_req();
        rand_slaves();
        if (!ok) begin
            cyc(err_e, "decode_err");
            return;
        end
        cyc(mk(oh, 1'b0, is_wr, strb, 1'b1, 1'b0, a, wd, 32'h0), "setup");

        for (int j = 0; j < 64; j++) begin
            rdy = (j >= waits) && (j != rst_at);
            rand_req();
            rand_slaves();
            PREADY[idx] = rdy;
            if (rdy) begin
                PSLVERR[idx]         = slverr;
                PRDATA[idx*32 +: 32] = rd;
            end
            if (j == rst_at) RST = 1'b1;
            exp_rd = (rdy && !is_wr) ? rd : 32'h0;
            cyc(mk(oh, 1'b1, is_wr, strb, !rdy, rdy && slverr, a, wd, exp_rd), "access");
            if (j == rst_at) begin
                RST = 1'b0;
                ren = 1'b0;
                wen = 1'b0;
                return;
            end
            if (rdy) return;
            if (j == TIMEOUT - 1) begin
                cyc(err_e, "timeout");
                return;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          waits;
        int          rst_at;
        int          lim;

        RST     = 1'b1;
        addr    = 32'h0;
        wdata   = 32'h0;
        ren     = 1'b0;
        wen     = 1'b0;
        byte_en = 4'h0;
        PRDATA  = '0;
        PREADY  = 4'h0;
        PSLVERR = 4'h0;
        cyc_k   = 0;
        res_lat = 0;
        repeat (2) @(posedge CLK);
        #1;
        cyc(mk(4'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0), "reset");
        RST = 1'b0;

        // Read from slave 1, zero wait states.
        run_txn(1'b0, 32'h8000_1004, $urandom(), 4'hF, 0, 1'b0, 32'hDEAD_BEEF, -1);
        check("rd_psel", 32'(res_psel), 32'h2);
        check("rd_lat", 32'(res_lat), 32'd3);
        check("rd_data", res_rdata, 32'hDEAD_BEEF);
        check("rd_err", 32'(res_err), 32'h0);

        // Write to slave 3 with two wait states.
        run_txn(1'b1, 32'h8000_3000, 32'h1234_5678, 4'b0011, 2, 1'b0, $urandom(), -1);
        check("wr_psel", 32'(res_psel), 32'h8);
        check("wr_lat", 32'(res_lat), 32'd5);
        check("wr_rdata", res_rdata, 32'h0);

        // Decode errors: slave index 4 and just below the window.
        run_txn(1'b0, 32'h8000_4000, $urandom(), 4'hF, 0, 1'b0, $urandom(), -1);
        check("dec_hi_lat", 32'(res_lat), 32'd2);
        check("dec_hi_err", 32'(res_err), 32'h1);
        check("dec_hi_psel", 32'(res_psel), 32'h0);
        run_txn(1'b0, 32'h7FFF_FFFC, $urandom(), 4'hF, 0, 1'b0, $urandom(), -1);
        check("dec_lo_lat", 32'(res_lat), 32'd2);
        check("dec_lo_err", 32'(res_err), 32'h1);
        check("dec_lo_rdata", res_rdata, 32'h0);

        // Slave error on slave 0 at the window base.
        run_txn(1'b0, 32'h8000_0000, $urandom(), 4'hF, 0, 1'b1, $urandom(), -1);
        check("slverr_psel", 32'(res_psel), 32'h1);
        check("slverr_lat", 32'(res_lat), 32'd3);
        check("slverr_err", 32'(res_err), 32'h1);

        // Last word of slave 3's region.
        run_txn(1'b0, 32'h8000_3FFC, $urandom(), 4'hF, 0, 1'b0, 32'h0BAD_F00D, -1);
        check("edge_psel", 32'(res_psel), 32'h8);
        check("edge_data", res_rdata, 32'h0BAD_F00D);

        // Timeout: PREADY never comes, then a normal transfer follows.
        run_txn(1'b0, 32'h8000_2008, $urandom(), 4'hF, 10, 1'b0, $urandom(), -1);
        check("to_lat", 32'(res_lat), 32'd7);
        check("to_err", 32'(res_err), 32'h1);
        check("to_rdata", res_rdata, 32'h0);
        run_txn(1'b1, 32'h8000_2000, $urandom(), 4'hC, 1, 1'b0, $urandom(), -1);
        check("after_to_lat", 32'(res_lat), 32'd4);
        check("after_to_err", 32'(res_err), 32'h0);

        // Reset during a wait state, then a fresh read.
        run_txn(1'b0, 32'h8000_1000, $urandom(), 4'hF, 3, 1'b0, $urandom(), 1);
        check("rst_no_done", 32'(res_lat), 32'd0);
        run_txn(1'b0, 32'h8000_1008, $urandom(), 4'hF, 0, 1'b0, 32'hCAFE_F00D, -1);
        check("after_rst_lat", 32'(res_lat), 32'd3);
        check("after_rst_data", res_rdata, 32'hCAFE_F00D);

        // Randomized traffic, including back-to-back requests.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0: a = BASE + (32'($urandom_range(4, 7)) << 12) + (32'($urandom_range(0, 1023)) << 2);
                1: a = 32'($urandom_range(0, 32'h7FFF_FFFF));
                2: a = $urandom();
                default: a = BASE + (32'($urandom_range(0, 3)) << 12) + (32'($urandom_range(0, 1023)) << 2);
            endcase
            waits  = $urandom_range(0, 6);
            rst_at = -1;
            if (waits > 0 && $urandom_range(0, 19) == 0) begin
                lim    = (waits < TIMEOUT) ? waits : TIMEOUT;
                rst_at = $urandom_range(0, lim - 1);
            end
            run_txn(1'($urandom), a, $urandom(), 4'($urandom), waits, 1'($urandom),
                    $urandom(), rst_at);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_multi_bridge.md
Name: apb_multi_bridge

Overview:
- Parametrised bridge from the core's generic bus to an APB4 fabric.
- Replaces the single-slave bridge. Adds width parameters, N-slave address decode with one-hot PSEL, and an explicit SETUP/ACCESS sequence.
- Adds PSLVERR propagation, a decode-error path and a PREADY-timeout abort.
- Sits between the memory-side generic bus and the peripheral APB segment.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64); STRB_W = DATA_W/8 derived
NSLV, 4, number of APB slaves (1..16)
BASE_ADDR, 32'h8000_0000, start of slave window
REGION_LOG2, 12, log2 bytes per slave region; slave i = [BASE_ADDR + i<<REGION_LOG2, +2^REGION_LOG2)
TIMEOUT, 0, max ACCESS cycles awaiting PREADY; 0 = disabled
PPROT_VAL, 3'b000, constant driven on PPROT

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
addr  in  ADDR_W  request address
wdata  in  DATA_W  write data
ren  in  1  read request
wen  in  1  write request (wen wins if both set)
byte_en  in  STRB_W  byte enables
rdata  out  DATA_W  read data, valid when busy=0 and the op was a read
busy  out  1  low for exactly the completion cycle
error  out  1  high with busy=0 when the transfer failed
PADDR  out  ADDR_W  APB address
PSEL  out  NSLV  one-hot slave select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PWDATA  out  DATA_W  write data
PSTRB  out  STRB_W  strobes (0 on reads)
PPROT  out  3  = PPROT_VAL
PRDATA  in  NSLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NSLV  slave ready
PSLVERR  in  NSLV  slave error

Behaviour:
- Reset: while RST is high at a CLK edge, the state becomes IDLE and the timeout counter and request register clear. Outputs then read: PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, busy=1, error=0, rdata=0. Reset mid-transfer abandons the transfer silently, with no completion pulse.
- States: IDLE, SETUP, ACCESS, RESP_ERR.
- IDLE:
  - busy=1 and all APB outputs are held at their reset values.
  - When ren|wen is seen at an edge, latch addr, wdata, wen, byte_en and the decoded slave index.
  - Valid decode -> SETUP. Address outside the window, or index >= NSLV -> RESP_ERR.
- SETUP (one cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB come from the latched request. Always -> ACCESS.
- ACCESS:
  - PSEL[idx]=1 and PENABLE=1.
  - If PREADY[idx]=1: this is the completion cycle. busy=0, error=PSLVERR[idx], rdata=PRDATA slice idx on reads (0 on writes). Next state IDLE.
  - If PREADY[idx]=0: stay in ACCESS and increment the counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without PREADY: -> RESP_ERR, and PSEL/PENABLE drop next cycle.
- RESP_ERR (one cycle): PSEL=0, PENABLE=0, busy=0, error=1, rdata=0. Next state IDLE.
- Latency:
  - Minimum 3 cycles from the request edge to busy low: IDLE, SETUP, ACCESS with PREADY=1.
  - Decode error completes in 2 cycles.
  - After any completion the bridge returns to IDLE for at least one cycle. A requester still asserting ren/wen there starts a new transfer.
- Stability: requester inputs are ignored outside IDLE, so changing them mid-transfer has no effect. The APB address, control and data outputs stay constant from SETUP through ACCESS.
- Decode arithmetic: offset = addr - BASE_ADDR, computed ADDR_W-bit unsigned, in range iff addr >= BASE_ADDR. idx = offset >> REGION_LOG2.
- Only PREADY/PSLVERR/PRDATA of the selected slave are observed. Other slaves' signals are don't-care.
- The counter is clog2(TIMEOUT+1) bits and saturates, so it never wraps.

Decomposition:
- Shared package apb_pkg holds:
  - state enum apb_state_t (IDLE, SETUP, ACCESS, RESP_ERR);
  - PPROT bit constants;
  - request struct using the package maxima ADDR_MAX=64 and DATA_MAX=64, with the bridge using the low bits.
- Sub-module apb_addr_decoder: combinational addr -> {valid, idx, onehot}, with the same parameters. Used in IDLE only.

Test Plan:
- Read, slave 1 (NSLV=4, REGION_LOG2=12): ren, addr=0x8000_1004; slave returns PREADY=1 with PRDATA=0xDEAD_BEEF in the first ACCESS cycle.
  -> SETUP shows PSEL=4'b0010, PENABLE=0, PADDR=0x8000_1004.
  -> ACCESS shows PENABLE=1, busy=0, rdata=0xDEAD_BEEF, error=0.
  -> 3 cycles total.
- Write, 2 wait states: wen, addr=0x8000_3000, wdata=0x1234_5678, byte_en=4'b0011; PREADY low 2 cycles.
  -> PSEL=4'b1000, PWRITE=1, PSTRB=0011 stable throughout; busy low on cycle 5 only.
- Decode error: ren, addr=0x8000_4000 (idx=4), then addr=0x7FFF_FFFC.
  -> PSEL stays 0; RESP_ERR gives busy=0, error=1, rdata=0 on cycle 2 in both cases.
- PSLVERR: read slave 0 with PREADY=1 and PSLVERR=1.
  -> busy=0, error=1 in the ACCESS cycle; next cycle IDLE.
- Timeout (TIMEOUT=4): PREADY never asserts.
  -> ACCESS held 4 cycles, then RESP_ERR with error=1 and PSEL=0; the bridge accepts a following request normally.
- Reset mid-ACCESS: assert RST for 1 cycle during a wait state.
  -> next cycle PSEL=0, PENABLE=0, busy=1, error=0, no completion pulse; a new read afterwards completes in 3 cycles.
